// File: rtl/add_image_deadlock_pkg.sv
// Shared types and widths for the add_image dataflow deadlock responder.
package add_image_deadlock_pkg;

    localparam int unsigned STATUS_AXIS_W = 5;
    localparam int unsigned STATUS_IDLE_W = 14;
    localparam int unsigned STATUS_CHAN_W = 5;
    localparam int unsigned EVENT_CNT_W   = 16;
    localparam int unsigned QUAL_CNT_W    = 16;
    localparam int unsigned REC_CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_QUALIFY    = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_RECOVER    = 3'd3,
        ST_WAIT_CLEAR = 3'd4
    } dl_state_e;

endpackage

// File: rtl/add_image_deadlock_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear together with increment loads 1.
module add_image_deadlock_sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? WIDTH'(1) : '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/add_image_deadlock_responder.sv
// Debounces the dataflow deadlock flag, snapshots process status, raises a sticky irq and optionally flushes.
module add_image_deadlock_responder
    import add_image_deadlock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RECOVER_CYCLES  = 8,
    parameter int unsigned AUTO_RECOVER    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     block,
    input  logic [STATUS_AXIS_W-1:0] axis_block_sigs,
    input  logic [STATUS_IDLE_W-1:0] inst_idle_sigs,
    input  logic [STATUS_CHAN_W-1:0] inst_block_sigs,
    input  logic                     irq_ack,
    output logic                     irq,
    output logic                     flush,
    output logic [STATUS_AXIS_W-1:0] snap_axis,
    output logic [STATUS_IDLE_W-1:0] snap_idle,
    output logic [STATUS_CHAN_W-1:0] snap_chan,
    output logic [EVENT_CNT_W-1:0]   event_cnt,
    output logic [2:0]               state_dbg
);

    localparam logic [QUAL_CNT_W-1:0] QUAL_LAST = QUAL_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REC_CNT_W-1:0]  REC_LAST  = REC_CNT_W'(RECOVER_CYCLES - 1);

    logic [1:0]               r_rst_sync;
    logic                     w_rst_n;
    dl_state_e                r_state;
    dl_state_e                w_next;
    logic [REC_CNT_W-1:0]     r_rec_cnt;
    logic                     r_flush;
    logic                     r_irq;
    logic [STATUS_AXIS_W-1:0] r_snap_axis;
    logic [STATUS_IDLE_W-1:0] r_snap_idle;
    logic [STATUS_CHAN_W-1:0] r_snap_chan;
    logic [QUAL_CNT_W-1:0]    w_qual_cnt;
    logic                     w_qual_clr;
    logic                     w_qual_inc;
    logic                     w_capture;

    // Assertion is immediate; release is delayed by two clock edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n   = r_rst_sync[1];
    assign w_capture = (r_state == ST_CAPTURE);

    assign w_qual_clr = !((r_state == ST_QUALIFY) && enable && block);
    assign w_qual_inc = enable && block && ((r_state == ST_ARMED) || (r_state == ST_QUALIFY));

    add_image_deadlock_sat_cnt #(.WIDTH(QUAL_CNT_W)) u_qual_cnt (
        .i_clk   (clock),
        .i_rst_n (w_rst_n),
        .i_clr   (w_qual_clr),
        .i_inc   (w_qual_inc),
        .o_cnt   (w_qual_cnt)
    );

    add_image_deadlock_sat_cnt #(.WIDTH(EVENT_CNT_W)) u_event_cnt (
        .i_clk   (clock),
        .i_rst_n (w_rst_n),
        .i_clr   (1'b0),
        .i_inc   (w_capture),
        .o_cnt   (event_cnt)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ARMED: begin
                if (enable && block) begin
                    w_next = (QUAL_LAST == '0) ? ST_CAPTURE : ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                if (!block) begin
                    w_next = ST_ARMED;
                end else if (w_qual_cnt == QUAL_LAST) begin
                    w_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_next = (AUTO_RECOVER != 0) ? ST_RECOVER : ST_WAIT_CLEAR;
            end
            ST_RECOVER: begin
                if (r_rec_cnt == REC_LAST) begin
                    w_next = ST_WAIT_CLEAR;
                end
            end
            ST_WAIT_CLEAR: begin
                if (!block) begin
                    w_next = ST_ARMED;
                end
            end
            default: w_next = ST_ARMED;
        endcase
        if (!enable) begin
            w_next = ST_ARMED;
        end
    end

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_ARMED;
            r_rec_cnt   <= '0;
            r_flush     <= 1'b0;
            r_irq       <= 1'b0;
            r_snap_axis <= '0;
            r_snap_idle <= '0;
            r_snap_chan <= '0;
        end else begin
            r_state   <= w_next;
            r_rec_cnt <= ((r_state == ST_RECOVER) && (w_next == ST_RECOVER)) ?
                         r_rec_cnt + REC_CNT_W'(1) : '0;
            r_flush   <= (w_next == ST_RECOVER);
            // A capture beats a coincident acknowledge.
            if (w_capture) begin
                r_irq       <= 1'b1;
                r_snap_axis <= axis_block_sigs;
                r_snap_idle <= inst_idle_sigs;
                r_snap_chan <= inst_block_sigs;
            end else if (irq_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign flush     = r_flush && enable;
    assign irq       = r_irq;
    assign snap_axis = r_snap_axis;
    assign snap_idle = r_snap_idle;
    assign snap_chan = r_snap_chan;
    assign state_dbg = r_state;

endmodule

// File: doc/add_image_deadlock_responder.md
ADD_IMAGE_DEADLOCK_RESPONDER -- requirements
Module: add_image_deadlock_responder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive cycles of block high needed to declare a deadlock; legal range 1..65535.
REQ-002 SHALL have parameter RECOVER_CYCLES, default 8: flush pulse length in cycles; legal range 1..255.
REQ-003 SHALL have parameter AUTO_RECOVER, default 1: 1 issues a flush after capture, 0 only reports.
REQ-004 SHALL have port clock, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1: arms the responder.
REQ-007 SHALL have port block, input, 1: deadlock flag from the dataflow deadlock monitor.
REQ-008 SHALL have ports axis_block_sigs [4:0], inst_idle_sigs [13:0] and inst_block_sigs [4:0], all inputs: live process status, captured as a snapshot.
REQ-009 SHALL have port irq_ack, input, 1: clears irq.
REQ-010 SHALL have port irq, output, 1: sticky deadlock interrupt.
REQ-011 SHALL have port flush, output, 1: recovery pulse to the dataflow region.
REQ-012 SHALL have ports snap_axis [4:0], snap_idle [13:0] and snap_chan [4:0], all outputs: status captured at detection.
REQ-013 SHALL have port event_cnt, output, 16: number of detected deadlocks.
REQ-014 SHALL have port state_dbg, output, 3: current FSM state encoding.

Function
REQ-015 SHALL implement the FSM states ARMED(0), QUALIFY(1), CAPTURE(2), RECOVER(3) and WAIT_CLEAR(4).
REQ-016 ARMED: on enable=1 and block=1, SHALL go to QUALIFY and load qual_cnt=1; otherwise SHALL stay in ARMED.
REQ-017 QUALIFY with block=1: SHALL increment qual_cnt; on the cycle qual_cnt reaches DEBOUNCE_CYCLES, SHALL go to CAPTURE. With DEBOUNCE_CYCLES=1, ARMED SHALL go directly to CAPTURE.
REQ-018 QUALIFY with block=0: SHALL return to ARMED and clear qual_cnt (glitch rejection, no event recorded).
REQ-019 CAPTURE: SHALL last exactly 1 cycle. In that cycle it SHALL register the snap_* outputs from the inputs present that cycle, increment event_cnt saturating at 0xFFFF, and set irq.
REQ-020 After CAPTURE: if AUTO_RECOVER=1, SHALL go to RECOVER; otherwise SHALL go to WAIT_CLEAR.
REQ-021 RECOVER: flush=1 for exactly RECOVER_CYCLES consecutive cycles, starting the cycle after CAPTURE, then SHALL go to WAIT_CLEAR.
REQ-022 WAIT_CLEAR: SHALL go to ARMED on the first cycle block=0; a deadlock SHALL never be counted twice.
REQ-023 irq SHALL be cleared by irq_ack=1 in any state; if set and clear coincide in the CAPTURE cycle, set SHALL win.
REQ-024 enable=0 SHALL force the FSM to ARMED on the next edge, clear qual_cnt and deassert flush at once (combinationally gated); irq, snap_* and event_cnt SHALL be retained.
REQ-025 flush SHALL be a registered output, except for the enable gating in REQ-024; no other output SHALL combinationally depend on an input.
REQ-026 snap_* SHALL change only in CAPTURE.

Reset
REQ-027 While reset=0 (asynchronous assertion), SHALL set: state ARMED, qual_cnt 0, recover counter 0, irq 0, flush 0, snap_axis 0, snap_idle 0, snap_chan 0, event_cnt 0.
REQ-028 Reset release SHALL be synchronised to clock through a 2-flop release synchroniser; the first state transition can occur no earlier than the 2nd rising edge after release.
REQ-029 Reset asserted during RECOVER SHALL drop flush immediately.

Structure
REQ-030 Package add_image_deadlock_pkg SHALL hold the state enum, the widths STATUS_AXIS_W=5, STATUS_IDLE_W=14 and STATUS_CHAN_W=5, and EVENT_CNT_W=16.
REQ-031 Sub-module add_image_deadlock_sat_cnt (parameterised width, saturating increment, synchronous clear) SHALL be used for both qual_cnt and event_cnt.

Verification
REQ-032 block=1 for 10 cycles with DEBOUNCE_CYCLES=16 -> no CAPTURE, irq=0, event_cnt=0, state returns to ARMED.
REQ-033 block=1 held for 16 cycles with inst_idle_sigs=0x2A5A -> irq=1 the cycle after the 16th block-high edge, snap_idle=0x2A5A, event_cnt=1, then flush high for exactly 8 cycles.
REQ-034 block held high 100 cycles, then low, then high again for 16 cycles -> event_cnt=2 (not more).
REQ-035 AUTO_RECOVER=0, a deadlock is detected, then irq_ack pulsed -> flush never asserted, irq=0 after the ack, snapshot retained.
REQ-036 enable dropped mid-RECOVER at flush cycle 3 -> flush=0 at once, state ARMED next edge, irq stays 1.
REQ-037 event_cnt preloaded near saturation by 65536 events (with DEBOUNCE_CYCLES=1, RECOVER_CYCLES=1) -> event_cnt holds 0xFFFF; asynchronous reset mid-QUALIFY -> all outputs 0.
